writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback_pkg.sv | 46 ++++
 rtl/writeback_cond_eval.sv | 26 ++
 rtl/writeback.sv | 103 ++++++++++
 tb/tb_writeback.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared widths, flag bit positions, condition-code and FSM encodings for
// the writeback stage.
package writeback_pkg;

    localparam int REG_ADDR_WIDTH  = 5;
    localparam int DATAWIDTH       = 32;
    localparam int IM_ADDR_WIDTH   = 10;
    localparam int COND_CODE_WIDTH = 3;
    localparam int P_WIDTH         = 48;
    localparam int CNT_WIDTH       = 4;
    localparam int FLAG_WIDTH      = 3;

    // Status register layout is {N,Z,C}.
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [COND_CODE_WIDTH-1:0] {
        COND_AL = 3'b000,
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_MI = 3'b011,
        COND_PL = 3'b100,
        COND_CS = 3'b101,
        COND_CC = 3'b110,
        COND_NV = 3'b111
    } cond_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } wb_state_t;

    // Flags produced by an execute result: bit DATAWIDTH carries the carry-out.
    function automatic logic [FLAG_WIDTH-1:0] flags_from_result(
        input logic [DATAWIDTH:0] res
    );
        logic [FLAG_WIDTH-1:0] f;
        f         = '0;
        f[FLAG_N] = res[DATAWIDTH-1];
        f[FLAG_Z] = (res[DATAWIDTH-1:0] == '0);
        f[FLAG_C] = res[DATAWIDTH];
        return f;
    endfunction

endpackage

// File: rtl/writeback_cond_eval.sv
// Combinational branch-condition decode against the {N,Z,C} status flags.
module cond_eval
    import writeback_pkg::*;
(
    input  logic [COND_CODE_WIDTH-1:0] condcode,
    input  logic [FLAG_WIDTH-1:0]      flags,
    output logic                       taken
);

    always_comb begin
        // NOTE: default assigned first so no path leaves taken unassigned (no latch).
        taken = 1'b0;
        case (cond_t'(condcode))
            COND_AL: taken = 1'b1;
            COND_EQ: taken = flags[FLAG_Z];
            COND_NE: taken = ~flags[FLAG_Z];
            COND_MI: taken = flags[FLAG_N];
            COND_PL: taken = ~flags[FLAG_N];
            COND_CS: taken = flags[FLAG_C];
            COND_CC: taken = ~flags[FLAG_C];
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/writeback.sv
// Writeback stage: registers execute results into the register file, keeps
// the status flags, resolves branches and squashes younger instructions.
module writeback
    import writeback_pkg::*;
#(
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_WIDTH-1:0]  addr_rd_i,
    input  logic                       regfile_we_w_i,
    input  logic                       regfile_we_uhw_i,
    input  logic                       branchen_i,
    input  logic [COND_CODE_WIDTH-1:0] condcode_i,
    input  logic [IM_ADDR_WIDTH-1:0]   branchtrgt_i,
    input  logic                       sr_we_i,
    input  logic [P_WIDTH-1:0]         p_i,
    output logic [REG_ADDR_WIDTH-1:0]  rf_addr_o,
    output logic [DATAWIDTH-1:0]       rf_data_o,
    output logic                       rf_we_w_o,
    output logic                       rf_we_uhw_o,
    output logic [FLAG_WIDTH-1:0]      flags_o,
    output logic                       redirect_o,
    output logic [IM_ADDR_WIDTH-1:0]   redirect_pc_o,
    output logic                       flushing_o
);

    localparam logic [CNT_WIDTH-1:0] FLUSH_LOAD = CNT_WIDTH'(FLUSH_CYCLES);

    wb_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic                 squash;
    logic                 cond_true;
    logic                 taken;
    logic                 unused_p_hi;

    assign unused_p_hi = ^p_i[P_WIDTH-1:DATAWIDTH+1];
    assign squash      = (state == ST_FLUSH);
    assign flushing_o  = squash;

    // Evaluated on the flag register as it stands, before any same-cycle update.
    cond_eval u_cond_eval (
        .condcode (condcode_i),
        .flags    (flags_o),
        .taken    (cond_true)
    );

    assign taken = branchen_i & cond_true & ~squash;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (taken) begin
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (cnt <= CNT_WIDTH'(1)) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rf_addr_o     <= '0;
            rf_data_o     <= '0;
            rf_we_w_o     <= 1'b0;
            rf_we_uhw_o   <= 1'b0;
            flags_o       <= '0;
            redirect_o    <= 1'b0;
            redirect_pc_o <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            rf_addr_o     <= addr_rd_i;
            rf_data_o     <= p_i[DATAWIDTH-1:0];
            rf_we_w_o     <= regfile_we_w_i & ~squash;
            rf_we_uhw_o   <= regfile_we_uhw_i & ~squash;
            redirect_o    <= taken;
            redirect_pc_o <= branchtrgt_i;
            if (sr_we_i && !squash) begin
                flags_o <= flags_from_result(p_i[DATAWIDTH:0]);
            end
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized
// traffic against a countdown-based reference model.
module tb_writeback;

    localparam int FC = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  addr_rd;
    logic        we_w;
    logic        we_uhw;
    logic        br;
    logic [2:0]  cond;
    logic [9:0]  trgt;
    logic        sr_we;
    logic [47:0] p;

    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic        rf_we_w_o;
    logic        rf_we_uhw_o;
    logic [2:0]  flags_o;
    logic        redirect_o;
    logic [9:0]  redirect_pc_o;
    logic        flushing_o;

    writeback #(.FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_rd_i        (addr_rd),
        .regfile_we_w_i   (we_w),
        .regfile_we_uhw_i (we_uhw),
        .branchen_i       (br),
        .condcode_i       (cond),
        .branchtrgt_i     (trgt),
        .sr_we_i          (sr_we),
        .p_i              (p),
        .rf_addr_o        (rf_addr_o),
        .rf_data_o        (rf_data_o),
        .rf_we_w_o        (rf_we_w_o),
        .rf_we_uhw_o      (rf_we_uhw_o),
        .flags_o          (flags_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .flushing_o       (flushing_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state: flags as {N,Z,C}, squash window as a plain countdown.
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we_w, m_we_uhw, m_redir;
    logic [2:0]  m_flags;
    logic [9:0]  m_pc;
    int          m_left;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit cond_holds(input logic [2:0] c, input logic [2:0] f);
        bit n, z, cy;
        n  = f[2];
        z  = f[1];
        cy = f[0];
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return cy;
            3'd6: return !cy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_addr = '0; m_data = '0; m_we_w = 0; m_we_uhw = 0;
        m_redir = 0; m_flags = '0; m_pc = '0; m_left = 0;
    endtask

    task automatic model_step();
        bit sq, tk;
        sq       = (m_left > 0);
        tk       = br && cond_holds(cond, m_flags) && !sq;
        m_addr   = addr_rd;
        m_data   = p[31:0];
        m_we_w   = we_w && !sq;
        m_we_uhw = we_uhw && !sq;
        m_redir  = tk;
        m_pc     = trgt;
        if (sr_we && !sq)
            m_flags = {p[31], p[31:0] == 32'd0, p[32]};
        if (tk)
            m_left = FC;
        else if (m_left > 0)
            m_left--;
    endtask

    task automatic compare_all();
        check("rf_addr",     48'(rf_addr_o),     48'(m_addr));
        check("rf_data",     48'(rf_data_o),     48'(m_data));
        check("rf_we_w",     48'(rf_we_w_o),     48'(m_we_w));
        check("rf_we_uhw",   48'(rf_we_uhw_o),   48'(m_we_uhw));
        check("flags",       48'(flags_o),       48'(m_flags));
        check("redirect",    48'(redirect_o),    48'(m_redir));
        check("redirect_pc", 48'(redirect_pc_o), 48'(m_pc));
        check("flushing",    48'(flushing_o),    48'(m_left > 0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"},  48'(rf_addr_o),     48'd0);
        check({tag, "_data"},  48'(rf_data_o),     48'd0);
        check({tag, "_wew"},   48'(rf_we_w_o),     48'd0);
        check({tag, "_weuhw"}, 48'(rf_we_uhw_o),   48'd0);
        check({tag, "_flags"}, 48'(flags_o),       48'd0);
        check({tag, "_redir"}, 48'(redirect_o),    48'd0);
        check({tag, "_pc"},    48'(redirect_pc_o), 48'd0);
        check({tag, "_flush"}, 48'(flushing_o),    48'd0);
    endtask

    task automatic drive(input logic [4:0] a, input logic ww, input logic wu, input logic b,
                         input logic [2:0] c, input logic [9:0] t, input logic s,
                         input logic [47:0] pv);
        addr_rd = a; we_w = ww; we_uhw = wu; br = b; cond = c; trgt = t; sr_we = s; p = pv;
    endtask

    task automatic nop();
        drive(5'd0, 0, 0, 0, 3'd0, 10'd0, 0, 48'd0);
    endtask

    // Advance one clock edge, update the model from the held inputs, compare #1 later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all_zero(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        nop();
        model_reset();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Result of zero sets Z only; no write strobes.
        drive(5'd3, 0, 0, 0, 3'd0, 10'd0, 1, 48'h0);
        step();
        check("zflag", 48'(flags_o), 48'h2);
        check("zflag_nowe", 48'({rf_we_w_o, rf_we_uhw_o}), 48'd0);

        // Plain full-word write.
        drive(5'd5, 1, 0, 0, 3'd0, 10'd0, 0, 48'h0000_1234_5678);
        step();
        check("wr_we",   48'(rf_we_w_o), 48'd1);
        check("wr_addr", 48'(rf_addr_o), 48'd5);
        check("wr_data", 48'(rf_data_o), 48'h1234_5678);

        // Taken branch on Z, then FC squashed writes and a normal one.
        drive(5'd1, 0, 0, 1, 3'b001, 10'h040, 0, 48'h0);
        step();
        check("br_redir", 48'(redirect_o), 48'd1);
        check("br_pc",    48'(redirect_pc_o), 48'h040);
        for (int i = 0; i < FC; i++) begin
            drive(5'(i + 8), 1, 1, 0, 3'd0, 10'd0, 0, 48'(i + 100));
            step();
            check("sq_we", 48'(rf_we_w_o), 48'd0);
            check("sq_redir_pulse", 48'(redirect_o), 48'd0);
        end
        drive(5'd20, 1, 0, 0, 3'd0, 10'd0, 0, 48'h55);
        step();
        check("post_flush_we", 48'(rf_we_w_o), 48'd1);

        // Same-cycle flag write and branch: branch sees the old Z.
        drive(5'd0, 0, 0, 0, 3'd0, 10'd0, 1, 48'h0);
        step();
        drive(5'd0, 0, 0, 1, 3'b001, 10'h123, 1, 48'h1);
        step();
        check("same_cyc_redir", 48'(redirect_o), 48'd1);
        check("same_cyc_flags", 48'(flags_o), 48'h0);

        // Unconditional branch inside the flush window is ignored.
        nop();
        step();
        drive(5'd0, 0, 0, 1, 3'b000, 10'h3ff, 0, 48'h0);
        step();
        check("flush_br_redir", 48'(redirect_o), 48'd0);
        nop();
        step();
        check("flush_sched_on", 48'(flushing_o), 48'd1);
        step();
        check("flush_sched_off", 48'(flushing_o), 48'd0);

        // Reset mid-flush, then a write straight after release.
        drive(5'd0, 0, 0, 1, 3'b000, 10'h0aa, 0, 48'h0);
        step();
        nop();
        step();
        check("pre_rst_flush", 48'(flushing_o), 48'd1);
        async_reset("midrst");
        drive(5'd7, 1, 0, 0, 3'd0, 10'd0, 0, 48'h77);
        step();
        check("post_rst_we", 48'(rf_we_w_o), 48'd1);

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 2000; i++) begin
            logic [47:0] pv;
            pv = {$urandom(), $urandom()} & 48'hffff_ffff_ffff;
            if ($urandom_range(7) == 0) pv[31:0] = 32'd0;
            drive(5'($urandom()), 1'($urandom()), 1'($urandom()),
                  ($urandom_range(3) == 0), 3'($urandom()), 10'($urandom()),
                  1'($urandom()), pv);
            step();
            if ($urandom_range(199) == 0) async_reset("rnd_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
